// File: rtl/interrupt_responder_pkg.sv
// Shared types and defaults for the interrupt responder slice: FSM state encoding,
// IRQ line width, vector layout defaults, error codes and the vector address helper.
package interrupt_pkg;

    localparam int          IRQ_NUM_W                  = 2;
    localparam logic [31:0] DEFAULT_VECTOR_BASE        = 32'h0000_0040;
    localparam int          DEFAULT_VECTOR_STRIDE_LOG2 = 4;
    localparam int          DEFAULT_TIMEOUT_CYCLES     = 1024;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCEPT   = 2'd1,
        ST_SERVICE  = 2'd2,
        ST_COMPLETE = 2'd3
    } resp_state_e;

    typedef enum logic {
        ERR_NONE     = 1'b0,
        ERR_WATCHDOG = 1'b1
    } err_code_e;

    // Wraps modulo 2^32 so a large base plus a high line number simply rolls over.
    function automatic logic [31:0] vectorAddr(input logic [31:0]          base,
                                               input int                   strideLog2,
                                               input logic [IRQ_NUM_W-1:0] num);
        logic [31:0] offset;
        offset = {{(32-IRQ_NUM_W){1'b0}}, num} << strideLog2;
        return base + offset;
    endfunction

endpackage

// File: rtl/interrupt_responder_if.sv
// Request/acknowledge and core-redirect signals between controller/core (master)
// and the interrupt responder (slave).
interface interrupt_responder_if;
    import interrupt_pkg::*;

    logic                 i_IrqReq;
    logic [IRQ_NUM_W-1:0] i_IrqNumber;
    logic                 i_InstrBoundary;
    logic [31:0]          i_CurrentPc;
    logic                 i_Reti;
    logic                 o_AckAttended;
    logic                 o_AckComplete;
    logic                 o_Redirect;
    logic [31:0]          o_RedirectPc;
    logic                 o_InService;
    logic [IRQ_NUM_W-1:0] o_ServiceNumber;
    logic                 o_Err;

    modport master (
        output i_IrqReq, i_IrqNumber, i_InstrBoundary, i_CurrentPc, i_Reti,
        input  o_AckAttended, o_AckComplete, o_Redirect, o_RedirectPc,
               o_InService, o_ServiceNumber, o_Err
    );

    modport slave (
        input  i_IrqReq, i_IrqNumber, i_InstrBoundary, i_CurrentPc, i_Reti,
        output o_AckAttended, o_AckComplete, o_Redirect, o_RedirectPc,
               o_InService, o_ServiceNumber, o_Err
    );

endinterface

// File: rtl/interrupt_responder_watchdog.sv
// Service-time watchdog for the interrupt responder; only compiled when
// INT_RESPONDER_WATCHDOG_EN is defined.
`ifdef INT_RESPONDER_WATCHDOG_EN
module irq_service_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Active,
    output logic o_Timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] count_q;

    // Count is zero on the first active cycle because it is cleared while inactive.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count_q <= '0;
        end else if (!i_Active) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign o_Timeout = i_Active && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/interrupt_responder.sv
// Core-side interrupt responder: accepts a request at an instruction boundary, vectors,
// then restores the saved PC on RETI. Optional watchdog: INT_RESPONDER_WATCHDOG_EN.
module interrupt_responder
    import interrupt_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE        = DEFAULT_VECTOR_BASE,
    parameter int          VECTOR_STRIDE_LOG2 = DEFAULT_VECTOR_STRIDE_LOG2,
    parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    interrupt_responder_if.slave  bus
);

    resp_state_e          state_q;
    logic [31:0]          savedPc_q;
    logic [IRQ_NUM_W-1:0] serviceNumber_q;
    logic                 ackAttended_q;
    logic                 ackComplete_q;
    logic                 redirect_q;
    logic [31:0]          redirectPc_q;
    logic                 inService_q;
    err_code_e            errCode_q;
    logic                 timeout;

`ifdef INT_RESPONDER_WATCHDOG_EN
    irq_service_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Active  (state_q == ST_SERVICE),
        .o_Timeout (timeout)
    );
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
    assign timeout          = 1'b0;
`endif

    // Every output is a register set on the transition into the state it belongs to.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q         <= ST_IDLE;
            savedPc_q       <= '0;
            serviceNumber_q <= '0;
            ackAttended_q   <= 1'b0;
            ackComplete_q   <= 1'b0;
            redirect_q      <= 1'b0;
            redirectPc_q    <= '0;
            inService_q     <= 1'b0;
            errCode_q       <= ERR_NONE;
        end else begin
            ackAttended_q <= 1'b0;
            ackComplete_q <= 1'b0;
            redirect_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_IrqReq && bus.i_InstrBoundary) begin
                        state_q         <= ST_ACCEPT;
                        savedPc_q       <= bus.i_CurrentPc;
                        serviceNumber_q <= bus.i_IrqNumber;
                        ackAttended_q   <= 1'b1;
                        redirect_q      <= 1'b1;
                        redirectPc_q    <= vectorAddr(VECTOR_BASE, VECTOR_STRIDE_LOG2,
                                                      bus.i_IrqNumber);
                        inService_q     <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    state_q <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    // RETI takes priority over a coincident timeout and leaves the error clear.
                    if (bus.i_Reti || timeout) begin
                        state_q       <= ST_COMPLETE;
                        ackComplete_q <= 1'b1;
                        redirect_q    <= 1'b1;
                        redirectPc_q  <= savedPc_q;
                        inService_q   <= 1'b0;
                        if (!bus.i_Reti) begin
                            errCode_q <= ERR_WATCHDOG;
                        end
                    end
                end
                ST_COMPLETE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_AckAttended   = ackAttended_q;
    assign bus.o_AckComplete   = ackComplete_q;
    assign bus.o_Redirect      = redirect_q;
    assign bus.o_RedirectPc    = redirectPc_q;
    assign bus.o_InService     = inService_q;
    assign bus.o_ServiceNumber = serviceNumber_q;
    assign bus.o_Err           = (errCode_q == ERR_WATCHDOG);

endmodule

// File: doc/interrupt_responder.md
Name: interrupt_responder

Overview:
Core-side end of the interrupt request/acknowledge protocol driven by the interrupt controller (irq_req, irq_number, ack_attended, ack_complete). Accepts a pending request at an instruction boundary and redirects the core to the per-line vector address. It saves the interrupted PC and, on return-from-interrupt, restores it and signals completion back to the controller. One interrupt is in service at a time; there is no nesting.

Parameters:
VECTOR_BASE, 32'h0000_0040, byte address of vector 0
VECTOR_STRIDE_LOG2, 4, log2 of byte distance between vectors (stride 16)
TIMEOUT_CYCLES, 1024, watchdog limit in SERVICE (used only with optional feature)

Ports:
i_Clk  in  1  clock, rising edge
i_Rst  in  1  reset, asynchronous, active-high
i_IrqReq  in  1  level request from controller
i_IrqNumber  in  2  line number, valid while i_IrqReq=1
i_InstrBoundary  in  1  core may be interrupted this cycle
i_CurrentPc  in  32  PC of next instruction to execute at the boundary
i_Reti  in  1  core retiring return-from-interrupt (1-cycle pulse)
o_AckAttended  out  1  1-cycle pulse: request accepted
o_AckComplete  out  1  1-cycle pulse: service finished
o_Redirect  out  1  1-cycle pulse: core must load o_RedirectPc
o_RedirectPc  out  32  target PC, valid while o_Redirect=1
o_InService  out  1  interrupt handler running
o_ServiceNumber  out  2  line currently in service
o_Err  out  1  sticky watchdog error (constant 0 without feature)

Behaviour:
- Reset (async, i_Rst=1): state IDLE; all outputs 0; saved PC 0. Reset mid-service aborts silently, with no o_AckComplete.
- All outputs are registered.
- States: IDLE, ACCEPT, SERVICE, COMPLETE.
- IDLE: if i_IrqReq && i_InstrBoundary at edge N:
  - latch saved PC = i_CurrentPc and number = i_IrqNumber.
  - go to ACCEPT. In cycle N+1: o_AckAttended=1, o_Redirect=1, o_RedirectPc = VECTOR_BASE + (number << VECTOR_STRIDE_LOG2), computed mod 2^32.
- i_IrqReq without i_InstrBoundary: stay in IDLE and keep sampling; the request is never lost.
- ACCEPT: unconditional next state SERVICE. o_InService=1 and o_ServiceNumber=number from ACCEPT onward.
- SERVICE: i_IrqReq is ignored. On i_Reti, go to COMPLETE. In the next cycle: o_AckComplete=1, o_Redirect=1, o_RedirectPc=saved PC.
- COMPLETE: o_InService=0, o_ServiceNumber held. Next state IDLE. A request is not sampled in COMPLETE; earliest new acceptance is the first IDLE cycle.
- i_Reti in IDLE, ACCEPT or COMPLETE: ignored, no outputs.
- o_Redirect is only ever 1 in ACCEPT and COMPLETE cycles.
- Minimum spacing between o_AckAttended pulses is 4 cycles.

Optional Feature:
INT_RESPONDER_WATCHDOG_EN
- Defined:
  - a counter clears on entry to SERVICE and increments every SERVICE cycle.
  - when count reaches TIMEOUT_CYCLES-1 without i_Reti, go to COMPLETE (o_AckComplete and redirect to saved PC) and set o_Err=1.
  - o_Err stays set until reset.
  - i_Reti on the same cycle as timeout: i_Reti wins, o_Err unchanged.
- Undefined: no counter; o_Err tied 0; SERVICE waits indefinitely.

Decomposition:
- Package interrupt_pkg holds:
  - state encoding (IDLE/ACCEPT/SERVICE/COMPLETE)
  - IRQ_NUM_W=2
  - default VECTOR_BASE and VECTOR_STRIDE_LOG2
  - error code constants
- Sub-module irq_service_watchdog (counter + timeout flag) is instantiated only under INT_RESPONDER_WATCHDOG_EN.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> all outputs 0 immediately; deassert -> IDLE, no pulses.
2. Accept and vector: req=1, num=2, boundary=1, pc=0x0000_0100 -> next cycle AckAttended=1, Redirect=1, RedirectPc=0x0000_0060; one cycle later InService=1, ServiceNumber=2.
3. Return: Reti pulse in SERVICE -> next cycle AckComplete=1, Redirect=1, RedirectPc=0x0000_0100; following cycle InService=0.
4. Deferred and blocked requests: req with boundary=0 for 5 cycles -> no ack until boundary=1. A num=1 request during SERVICE -> no ack; accepted first IDLE cycle after COMPLETE, RedirectPc=0x0000_0050.
5. Reset during SERVICE -> no AckComplete ever emitted; subsequent req accepted normally.
6. With INT_RESPONDER_WATCHDOG_EN and TIMEOUT_CYCLES=8, no Reti -> AckComplete on cycle following 8th SERVICE cycle, Err=1 held until reset. Reti on timeout cycle -> Err stays 0.
